dm_arb: RTL

DM_ARB -- requirements
Module: dm_arb

---
 rtl/dm_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dm_arb.sv
// Two-port round-robin arbiter in front of a single-port data memory: IDLE -> ACC -> RESP.
// Define DM_ARB_RANGE_CHECK_EN to reject addresses >= MEM_DEPTH without touching memory.
module dm_arb #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              p0_req_i,
    input  logic              p0_wr_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    input  logic              p1_req_i,
    input  logic              p1_wr_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    output logic              p0_err_o,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              p1_err_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    output logic              m_we_o,
    output logic              m_re_o,
    input  logic [DATA_W-1:0] m_rdata_i
);

    typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              win_q, win_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    logic              gnt_sel;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oob;

    // Contention goes to the port not granted last; a lone requester always wins.
    assign gnt_sel   = (p0_req_i && p1_req_i) ? ~last_q : p1_req_i;
    assign sel_wr    = gnt_sel ? p1_wr_i    : p0_wr_i;
    assign sel_addr  = gnt_sel ? p1_addr_i  : p0_addr_i;
    assign sel_wdata = gnt_sel ? p1_wdata_i : p0_wdata_i;

`ifdef DM_ARB_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(MEM_DEPTH);
    assign sel_oob = ({1'b0, sel_addr} >= DepthW);
`else
    assign sel_oob = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        win_d   = win_q;
        last_d  = last_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (p0_req_i || p1_req_i) begin
                    wr_d    = sel_wr;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    win_d   = gnt_sel;
                    last_d  = gnt_sel;
                    err_d   = sel_oob;
                    if (sel_oob) begin
                        rdata_d = '0;
                        state_d = StResp;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StAcc: begin
                rdata_d = wr_q ? '0 : m_rdata_i;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            win_q   <= win_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    logic in_acc;
    logic in_resp;
    logic resp_err;

    assign in_acc  = (state_q == StAcc);
    assign in_resp = (state_q == StResp);

    // Memory bus is idle (all zero) outside ACC so an async reset quiets it at once.
    assign m_we_o    = in_acc & wr_q;
    assign m_re_o    = in_acc & ~wr_q;
    assign m_addr_o  = in_acc ? addr_q  : '0;
    assign m_wdata_o = in_acc ? wdata_q : '0;

`ifdef DM_ARB_RANGE_CHECK_EN
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign p0_ack_o   = in_resp & ~win_q;
    assign p1_ack_o   = in_resp &  win_q;
    assign p0_rdata_o = p0_ack_o ? rdata_q : '0;
    assign p1_rdata_o = p1_ack_o ? rdata_q : '0;
    assign p0_err_o   = p0_ack_o & resp_err;
    assign p1_err_o   = p1_ack_o & resp_err;

endmodule
